conv_window_gen: RTL

Sliding-window generator sitting directly downstream of the 2x2 max-pool stage and upstream of the second convolution layer. It accepts the pooled feature stream in raster order, one channel frame at a time, and buffers rows in line buffers. For every valid KERNEL x KERNEL window position it emits the full window as one flat vector, so the conv2 MAC array can consume one window per strobe.

---
 rtl/cnn_pkg.sv | 19 +
 rtl/conv_window_gen_line_buffer.sv | 29 ++
 rtl/conv_window_gen.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the LeNet feature pipeline.
// Geometry constants describe the pooled layer-1 output feeding conv2.
package cnn_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] feature_t;

    localparam int POOL_COLS     = 14;
    localparam int POOL_ROWS     = 14;
    localparam int POOL_CHANNELS = 6;
    localparam int CONV2_KERNEL  = 5;

    // Number of unpadded KxK window positions inside one rows x cols frame.
    function automatic int windowsPerFrame(input int rows, input int cols, input int k);
        return (rows - k + 1) * (cols - k + 1);
    endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of storage, addressed by column.
// The read port is combinational so the value stored at a column can be
// forwarded onward in the same cycle that a new value overwrites it.
module line_buffer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = POOL_COLS,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    assign o_rdata = mem_q[i_addr];

    // Storage write; contents are deliberately left uninitialised at reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Sliding KxK window generator between max-pool and conv2.
// Optional feature: define CONV_WINDOW_GEN_CHANNEL_TAG_EN to add the
// o_channel output, which tags each window with its source channel.
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int NUM_CHANNELS = POOL_CHANNELS,
    parameter int IMG_COLS     = POOL_COLS,
    parameter int IMG_ROWS     = POOL_ROWS,
    parameter int KERNEL       = CONV2_KERNEL,
    parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_nd,
    input  logic signed [DATA_WIDTH-1:0]        i_features,
    output logic [KERNEL*KERNEL*DATA_WIDTH-1:0] o_window,
    output logic                                o_nd,
    output logic                                o_done
`ifdef CONV_WINDOW_GEN_CHANNEL_TAG_EN
    ,
    output logic [CH_W-1:0]                     o_channel
`endif
);

    localparam int COL_W = $clog2(IMG_COLS);
    localparam int ROW_W = $clog2(IMG_ROWS);
    localparam int WIN_W = KERNEL * KERNEL * DATA_WIDTH;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_ROWS - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CHANNELS - 1);
    localparam logic [COL_W-1:0] COL_WIN_0 = COL_W'(KERNEL - 1);
    localparam logic [ROW_W-1:0] ROW_WIN_0 = ROW_W'(KERNEL - 1);

    logic [COL_W-1:0] colCnt_q, colCnt_d;
    logic [ROW_W-1:0] rowCnt_q, rowCnt_d;
    logic [CH_W-1:0]  chCnt_q,  chCnt_d;

    logic                  lbWe;
    logic [DATA_WIDTH-1:0] lbWdata [KERNEL-1];
    logic [DATA_WIDTH-1:0] lbRdata [KERNEL-1];

    logic [DATA_WIDTH-1:0] win_q [KERNEL][KERNEL];
    logic [DATA_WIDTH-1:0] win_d [KERNEL][KERNEL];
    logic [WIN_W-1:0]      flat_d;

    logic             winValid;
    logic             lastWin;
    logic [WIN_W-1:0] windowOut_q;
    logic             ndOut_q;
    logic             doneOut_q;

    // Raster position of the sample being accepted: column, then row, then channel.
    always_comb begin
        colCnt_d = colCnt_q;
        rowCnt_d = rowCnt_q;
        chCnt_d  = chCnt_q;
        if (i_nd) begin
            if (colCnt_q == COL_LAST) begin
                colCnt_d = '0;
                if (rowCnt_q == ROW_LAST) begin
                    rowCnt_d = '0;
                    chCnt_d  = (chCnt_q == CH_LAST) ? '0 : chCnt_q + 1'b1;
                end else begin
                    rowCnt_d = rowCnt_q + 1'b1;
                end
            end else begin
                colCnt_d = colCnt_q + 1'b1;
            end
        end
    end

    // A window is complete only once K rows and K columns of this frame exist,
    // which also keeps stale rows from earlier frames out of every window.
    assign winValid = i_nd && (rowCnt_q >= ROW_WIN_0) && (colCnt_q >= COL_WIN_0);
    assign lastWin  = winValid && (colCnt_q == COL_LAST) && (rowCnt_q == ROW_LAST)
                      && (chCnt_q == CH_LAST);
    assign lbWe     = i_nd && !i_rst;

    // Chain of row buffers: index 0 holds the oldest row, the last index the newest.
    for (genvar k = 0; k < KERNEL - 1; k++) begin : gLine
        if (k == KERNEL - 2) begin : gNewest
            assign lbWdata[k] = i_features;
        end else begin : gOlder
            assign lbWdata[k] = lbRdata[k+1];
        end

        line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_COLS),
            .ADDR_W     (COL_W)
        ) uLine (
            .i_clk   (i_clk),
            .i_we    (lbWe),
            .i_addr  (colCnt_q),
            .i_wdata (lbWdata[k]),
            .o_rdata (lbRdata[k])
        );
    end

    // Next window: shift every row left and append the current column on the right.
    always_comb begin
        win_d  = win_q;
        flat_d = '0;
        if (i_nd) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            for (int r = 0; r < KERNEL - 1; r++) begin
                win_d[r][KERNEL-1] = lbRdata[r];
            end
            win_d[KERNEL-1][KERNEL-1] = i_features;
        end
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) begin
                flat_d[(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH] = win_d[r][c];
            end
        end
    end

    // State update; the output window only loads on a valid strobe so it holds between strobes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            colCnt_q    <= '0;
            rowCnt_q    <= '0;
            chCnt_q     <= '0;
            ndOut_q     <= 1'b0;
            doneOut_q   <= 1'b0;
            windowOut_q <= '0;
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            colCnt_q  <= colCnt_d;
            rowCnt_q  <= rowCnt_d;
            chCnt_q   <= chCnt_d;
            ndOut_q   <= winValid;
            doneOut_q <= lastWin;
            if (i_nd) begin
                win_q <= win_d;
            end
            if (winValid) begin
                windowOut_q <= flat_d;
            end
        end
    end

    assign o_window = windowOut_q;
    assign o_nd     = ndOut_q;
    assign o_done   = doneOut_q;

`ifdef CONV_WINDOW_GEN_CHANNEL_TAG_EN
    logic [CH_W-1:0] channelOut_q;

    // Channel tag captured alongside the window it describes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            channelOut_q <= '0;
        end else if (winValid) begin
            channelOut_q <= chCnt_q;
        end
    end

    assign o_channel = channelOut_q;
`endif

endmodule
